img_pro_top: RTL and testbench
==============================

IMG_PRO_TOP -- requirements
Module: img_pro_top (companion timing source: img_driver)

Interface
REQ-001 SHALL have parameters: H_ACT 640 (active pixels per line), V_ACT 480 (active lines per frame), BOX_COLOR 24'hFF0000 (outline colour).
REQ-002 SHALL have ports:
  clk     in   1   single clock; all logic rising-edge.
  rst_n   in   1   reset, asynchronous, active-low.
  vs_i    in   1   vertical sync in.
  hs_i    in   1   horizontal sync in.
  de_i    in   1   data enable in; high for active pixels.
  data_i  in   24  RGB888 pixel in; non-zero means foreground.
  vs_o    out  1   vs_i delayed.
  hs_o    out  1   hs_i delayed.
  de_o    out  1   de_i delayed.
  data_o  out  24  processed pixel.
REQ-003 SHALL contain a submodule instance named u_img_rect that holds registers row_cnt and col_cnt (11 bits each), readable hierarchically by benches.

Function
REQ-004 SHALL register vs/hs/de/data with exactly 1 clk of latency; sync outputs are 1-cycle-delayed copies of the inputs.
REQ-005 col_cnt SHALL count output pixels in a line, 1-based: 1 on the first de_o cycle of a line, +1 on each further de_o cycle, reset to 0 when de_o is low.
REQ-006 row_cnt SHALL be 1-based: increments on each rising edge of de_o, clears to 0 on vs_o high; last pixel of a frame therefore shows de_o=1, row_cnt=480, col_cnt=640.
REQ-007 Per frame, bounding box (xmin, xmax, ymin, ymax) of foreground pixels SHALL be accumulated from the input-side position counters (same 1-based convention).
REQ-008 At vs rising edge, the accumulated box SHALL be latched as the draw box with valid=1 if any foreground pixel was seen, else valid=0; accumulators then reinitialise (min to max value, max to 0).
REQ-009 data_o SHALL equal BOX_COLOR when valid=1 and the pixel lies on the 1-pixel border (row in {ymin,ymax} with col in [xmin,xmax], or col in {xmin,xmax} with row in [ymin,ymax]); otherwise data_o SHALL equal the delayed data_i.
REQ-010 data_o SHALL be 0 when de_o is low.
REQ-011 Single-pixel box (xmin=xmax, ymin=ymax) SHALL draw that one pixel; a box touching the image edge SHALL draw normally, no wrap.
REQ-012 img_driver (clk, rst_n in; vs_o, hs_o, de_o out) SHALL generate 640x480 timing: H total 800 = sync 96, back porch 48, active 640, front porch 16; V total 525 = sync 2, back porch 33, active 480, front porch 10; sync pulses active-high; de_o high only in active H and active V; counters start at 0 after reset and wrap free-running.

Reset
REQ-013 While rst_n=0 (asynchronous), all outputs SHALL be 0, row_cnt and col_cnt 0, draw box valid=0, accumulators reinitialised.
REQ-014 First frame after reset SHALL pass data unchanged (no valid box); box appears from the second frame.
REQ-015 Reset asserted mid-frame SHALL discard partial accumulation; img_driver restarts at H=0, V=0.

Verification
REQ-016 img_driver free-run: de_o high for exactly 640 consecutive cycles per line, 480 lines per frame, frame period 420000 clk.
REQ-017 All-zero frame then all-zero frame: data_o==0 on all 307200 active pixels of both frames; last pixel flagged by row_cnt=480, col_cnt=640.
REQ-018 Frame with foreground 24'hFFFFFF in rows 100..200, cols 50..300, repeated: second frame outputs FF0000 on row 100 and 200 (cols 50..300) and cols 50/300 (rows 100..200); interior stays FFFFFF.
REQ-019 Single foreground pixel at (1,1) then blank frame: second frame data_o=FF0000 only at row 1, col 1.
REQ-020 Latency check: de_i/data_i edge appears on de_o/data_o exactly 1 clk later.
REQ-021 rst_n pulsed low at row 240: outputs go 0 immediately; following frame passes data unchanged.

Source files
------------

// File: rtl/img_pro_top_if.sv
// rtl/img_pro_top_if.sv - video stream bundle: syncs, data enable and RGB888 pixel
interface img_pro_top_if;
    logic        vs;
    logic        hs;
    logic        de;
    logic [23:0] data;

    modport master (output vs, hs, de, data);
    modport slave  (input  vs, hs, de, data);
endinterface

// File: rtl/img_pro_top.sv
// rtl/img_pro_top.sv - foreground bounding-box overlay with 1-clk video delay, plus a 640x480 timing source
module img_pro_top #(
    parameter int          H_ACT     = 640,
    parameter int          V_ACT     = 480,
    parameter logic [23:0] BOX_COLOR = 24'hFF0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vs_i,
    input  logic        hs_i,
    input  logic        de_i,
    input  logic [23:0] data_i,
    output logic        vs_o,
    output logic        hs_o,
    output logic        de_o,
    output logic [23:0] data_o
);
    img_pro_top_if vid_in ();
    img_pro_top_if vid_out ();

    assign vid_in.vs   = vs_i;
    assign vid_in.hs   = hs_i;
    assign vid_in.de   = de_i;
    assign vid_in.data = data_i;

    assign vs_o   = vid_out.vs;
    assign hs_o   = vid_out.hs;
    assign de_o   = vid_out.de;
    assign data_o = vid_out.data;

    img_rect #(
        .H_ACT    (H_ACT),
        .V_ACT    (V_ACT),
        .BOX_COLOR(BOX_COLOR)
    ) u_img_rect (
        .clk  (clk),
        .rst_n(rst_n),
        .vid_i(vid_in),
        .vid_o(vid_out)
    );
endmodule

module img_rect #(
    parameter int          H_ACT     = 640,
    parameter int          V_ACT     = 480,
    parameter logic [23:0] BOX_COLOR = 24'hFF0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    img_pro_top_if.slave         vid_i,
    img_pro_top_if.master        vid_o
);
    // Min accumulators start at the largest legal coordinate so any pixel wins.
    localparam logic [10:0] X_INIT = 11'(H_ACT);
    localparam logic [10:0] Y_INIT = 11'(V_ACT);

    logic        vs_q, vs_d, hs_q, hs_d, de_q, de_d;
    logic [23:0] data_q, data_d;
    logic [10:0] row_cnt, row_cnt_d, col_cnt, col_cnt_d;
    logic [10:0] xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
    logic        seen_q, seen_d;
    logic [10:0] bx0_q, bx0_d, bx1_q, bx1_d, by0_q, by0_d, by1_q, by1_d;
    logic        box_vld_q, box_vld_d;
    logic        in_x, in_y, on_border;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q      <= 1'b0;
            hs_q      <= 1'b0;
            de_q      <= 1'b0;
            data_q    <= '0;
            row_cnt   <= '0;
            col_cnt   <= '0;
            xmin_q    <= X_INIT;
            xmax_q    <= '0;
            ymin_q    <= Y_INIT;
            ymax_q    <= '0;
            seen_q    <= 1'b0;
            bx0_q     <= '0;
            bx1_q     <= '0;
            by0_q     <= '0;
            by1_q     <= '0;
            box_vld_q <= 1'b0;
        end else begin
            vs_q      <= vs_d;
            hs_q      <= hs_d;
            de_q      <= de_d;
            data_q    <= data_d;
            row_cnt   <= row_cnt_d;
            col_cnt   <= col_cnt_d;
            xmin_q    <= xmin_d;
            xmax_q    <= xmax_d;
            ymin_q    <= ymin_d;
            ymax_q    <= ymax_d;
            seen_q    <= seen_d;
            bx0_q     <= bx0_d;
            bx1_q     <= bx1_d;
            by0_q     <= by0_d;
            by1_q     <= by1_d;
            box_vld_q <= box_vld_d;
        end
    end

    // Counters are computed from the input side so they line up with de_o.
    always_comb begin
        vs_d      = vid_i.vs;
        hs_d      = vid_i.hs;
        de_d      = vid_i.de;
        data_d    = vid_i.data;
        col_cnt_d = vid_i.de ? col_cnt + 11'd1 : 11'd0;
        row_cnt_d = row_cnt;
        if (vid_i.vs)
            row_cnt_d = 11'd0;
        else if (vid_i.de && !de_q)
            row_cnt_d = row_cnt + 11'd1;

        xmin_d    = xmin_q;
        xmax_d    = xmax_q;
        ymin_d    = ymin_q;
        ymax_d    = ymax_q;
        seen_d    = seen_q;
        bx0_d     = bx0_q;
        bx1_d     = bx1_q;
        by0_d     = by0_q;
        by1_d     = by1_q;
        box_vld_d = box_vld_q;

        if (vid_i.vs && !vs_q) begin
            bx0_d     = xmin_q;
            bx1_d     = xmax_q;
            by0_d     = ymin_q;
            by1_d     = ymax_q;
            box_vld_d = seen_q;
            xmin_d    = X_INIT;
            xmax_d    = '0;
            ymin_d    = Y_INIT;
            ymax_d    = '0;
            seen_d    = 1'b0;
        end else if (de_q && (data_q != 24'd0)) begin
            seen_d = 1'b1;
            if (col_cnt < xmin_q) xmin_d = col_cnt;
            if (col_cnt > xmax_q) xmax_d = col_cnt;
            if (row_cnt < ymin_q) ymin_d = row_cnt;
            if (row_cnt > ymax_q) ymax_d = row_cnt;
        end
    end

    assign in_x      = (col_cnt >= bx0_q) && (col_cnt <= bx1_q);
    assign in_y      = (row_cnt >= by0_q) && (row_cnt <= by1_q);
    assign on_border = box_vld_q &&
                       ((((row_cnt == by0_q) || (row_cnt == by1_q)) && in_x) ||
                        (((col_cnt == bx0_q) || (col_cnt == bx1_q)) && in_y));

    assign vid_o.vs   = vs_q;
    assign vid_o.hs   = hs_q;
    assign vid_o.de   = de_q;
    assign vid_o.data = !de_q ? 24'd0 : (on_border ? BOX_COLOR : data_q);
endmodule

module img_driver #(
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int H_ACT  = 640,
    parameter int H_FP   = 16,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int V_ACT  = 480,
    parameter int V_FP   = 10
) (
    input  logic clk,
    input  logic rst_n,
    output logic vs_o,
    output logic hs_o,
    output logic de_o
);
    localparam logic [10:0] H_LAST  = 11'(H_SYNC + H_BP + H_ACT + H_FP - 1);
    localparam logic [10:0] V_LAST  = 11'(V_SYNC + V_BP + V_ACT + V_FP - 1);
    localparam logic [10:0] H_SYNCW = 11'(H_SYNC);
    localparam logic [10:0] V_SYNCW = 11'(V_SYNC);
    localparam logic [10:0] H_A0    = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_A1    = 11'(H_SYNC + H_BP + H_ACT);
    localparam logic [10:0] V_A0    = 11'(V_SYNC + V_BP);
    localparam logic [10:0] V_A1    = 11'(V_SYNC + V_BP + V_ACT);

    logic [10:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic        vs_q, vs_d, hs_q, hs_d, de_q, de_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            vs_q    <= 1'b0;
            hs_q    <= 1'b0;
            de_q    <= 1'b0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            vs_q    <= vs_d;
            hs_q    <= hs_d;
            de_q    <= de_d;
        end
    end

    always_comb begin
        h_cnt_d = (h_cnt_q == H_LAST) ? 11'd0 : h_cnt_q + 11'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST)
            v_cnt_d = (v_cnt_q == V_LAST) ? 11'd0 : v_cnt_q + 11'd1;
        hs_d = (h_cnt_q < H_SYNCW);
        vs_d = (v_cnt_q < V_SYNCW);
        de_d = (h_cnt_q >= H_A0) && (h_cnt_q < H_A1) && (v_cnt_q >= V_A0) && (v_cnt_q < V_A1);
    end

    assign vs_o = vs_q;
    assign hs_o = hs_q;
    assign de_o = de_q;
endmodule

// File: tb/tb_img_pro_top.sv
// tb/tb_img_pro_top.sv - scoreboard bench for img_pro_top driven by a reduced-size img_driver
module tb_img_pro_top;
    localparam int HA = 16, VA = 8;
    localparam int HS = 2, HB = 2, HF = 2, VS = 1, VB = 1, VF = 1;
    localparam int FRAME = (HS + HB + HA + HF) * (VS + VB + VA + VF);
    localparam logic [23:0] RED = 24'hFF0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vs_o, hs_o, de_o;
    logic [23:0] data_o;

    always #5 clk = ~clk;

    img_pro_top_if drv_if ();

    img_driver #(
        .H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF),
        .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_FP(VF)
    ) u_drv (
        .clk  (clk),
        .rst_n(rst_n),
        .vs_o (drv_if.vs),
        .hs_o (drv_if.hs),
        .de_o (drv_if.de)
    );

    img_pro_top #(.H_ACT(HA), .V_ACT(VA), .BOX_COLOR(RED)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vs_i  (drv_if.vs),
        .hs_i  (drv_if.hs),
        .de_i  (drv_if.de),
        .data_i(drv_if.data),
        .vs_o  (vs_o),
        .hs_o  (hs_o),
        .de_o  (de_o),
        .data_o(data_o)
    );

    typedef struct {
        int          row;
        int          col;
        logic [23:0] data;
    } pix_t;

    pix_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] pattern(input int f, input int r, input int c);
        case (f)
            0, 1, 7, 8, 9: return (r >= 2 && r <= 5 && c >= 3 && c <= 10) ? 24'hFFFFFF : 24'h0;
            2:             return (r == 1 && c == 1) ? 24'h123456 : 24'h0;
            5, 6:          return (r >= 6 && r <= 8 && c >= 12 && c <= 16) ? 24'h0000A5 : 24'h0;
            default:       return 24'h0;
        endcase
    endfunction

    int   frame = -1, row = 0, col = 0, run = 0, last_vs_cyc = -1, rst_hold = 0;
    int   ax0, ax1, ay0, ay1, bx0, bx1, by0, by1;
    bit   aseen = 0, bvld = 0, full_frame = 0, did_reset = 0, border;
    logic vs_p = 0, hs_p = 0, de_p = 0, vs, de;
    logic [23:0] d;
    pix_t e;

    task automatic clear_accum();
        ax0 = 1 << 20; ax1 = -1; ay0 = 1 << 20; ay1 = -1; aseen = 0;
    endtask

    initial begin
        drv_if.data = '0;
        clear_accum();
        repeat (3) @(negedge clk);
        chk("reset_outputs", {5'd0, vs_o, hs_o, de_o, data_o}, 32'd0);
        chk("reset_row_cnt", 32'(dut.u_img_rect.row_cnt), 32'd0);
        chk("reset_col_cnt", 32'(dut.u_img_rect.col_cnt), 32'd0);
        chk("reset_box_vld", 32'(dut.u_img_rect.box_vld_q), 32'd0);
        rst_n = 1'b1;

        for (int cyc = 0; cyc < 6000 && frame < 10; cyc++) begin
            @(negedge clk);
            if (rst_hold > 0) begin
                chk("rst_hold_outputs", {5'd0, vs_o, hs_o, de_o, data_o}, 32'd0);
                rst_hold--;
                if (rst_hold == 0) rst_n = 1'b1;
                continue;
            end

            chk("vs_latency", 32'(vs_o), 32'(vs_p));
            chk("hs_latency", 32'(hs_o), 32'(hs_p));
            chk("de_latency", 32'(de_o), 32'(de_p));
            if (de_o) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("data_o", 32'(data_o), 32'(e.data));
                    chk("col_cnt", 32'(dut.u_img_rect.col_cnt), 32'(e.col));
                    chk("row_cnt", 32'(dut.u_img_rect.row_cnt), 32'(e.row));
                end
            end else begin
                chk("data_idle", 32'(data_o), 32'd0);
            end

            if (!did_reset && frame == 7 && row == 4 && drv_if.de) begin
                did_reset = 1;
                rst_n = 1'b0;
                #1;
                chk("rst_async_outputs", {5'd0, vs_o, hs_o, de_o, data_o}, 32'd0);
                chk("rst_async_row_cnt", 32'(dut.u_img_rect.row_cnt), 32'd0);
                chk("rst_async_box_vld", 32'(dut.u_img_rect.box_vld_q), 32'd0);
                exp_q.delete();
                clear_accum();
                row = 0; col = 0; run = 0; bvld = 0;
                vs_p = 0; hs_p = 0; de_p = 0;
                last_vs_cyc = -1; full_frame = 0;
                drv_if.data = '0;
                rst_hold = 3;
                continue;
            end

            vs = drv_if.vs;
            de = drv_if.de;
            if (vs && !vs_p) begin
                if (last_vs_cyc >= 0) chk("frame_period", 32'(cyc - last_vs_cyc), 32'(FRAME));
                last_vs_cyc = cyc;
                if (full_frame) chk("lines_per_frame", 32'(row), 32'(VA));
                chk("sb_drain", 32'(exp_q.size()), 32'd0);
                bvld = aseen; bx0 = ax0; bx1 = ax1; by0 = ay0; by1 = ay1;
                clear_accum();
                frame++;
                full_frame = 1;
            end
            if (vs) row = 0;
            if (de) begin
                if (!de_p) begin
                    row++;
                    col = 1;
                end else begin
                    col++;
                end
                run++;
            end else begin
                if (de_p) chk("line_len", 32'(run), 32'(HA));
                run = 0;
                col = 0;
            end

            if (de) begin
                d = pattern(frame, row, col);
                if (d != 0) begin
                    aseen = 1;
                    if (col < ax0) ax0 = col;
                    if (col > ax1) ax1 = col;
                    if (row < ay0) ay0 = row;
                    if (row > ay1) ay1 = row;
                end
                border = bvld &&
                         (((row == by0 || row == by1) && col >= bx0 && col <= bx1) ||
                          ((col == bx0 || col == bx1) && row >= by0 && row <= by1));
                exp_q.push_back('{row: row, col: col, data: border ? RED : d});
            end else begin
                d = 24'($urandom);
            end
            drv_if.data = d;
            vs_p = vs;
            hs_p = drv_if.hs;
            de_p = de;
        end

        chk("frames_done", 32'(frame >= 10), 32'd1);
        chk("reset_exercised", 32'(did_reset), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
